// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and constants for the TX frame scheduler: FSM state encoding,
// frame field widths and default timing parameters.
package tx_sched_pkg;

    localparam int FRAME_LEN_W        = 16;
    localparam int FRAME_TYPE_W       = 4;
    localparam int TIMEOUT_W          = 16;
    localparam int DEF_IFS_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEF_MAX_LEN        = 4095;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        VLD,
        WAIT_DONE,
        GAP
    } sched_state_e;

    // Zero-length and over-long frames are both refused at arbitration time.
    function automatic logic len_ok(input logic [FRAME_LEN_W-1:0] len,
                                    input logic [FRAME_LEN_W-1:0] max_len);
        return (len != '0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Frame request handshake between one requester (master) and the scheduler
// (slave): valid/len/type held by the requester until the scheduler acks.
interface tx_frame_scheduler_if;
    import tx_sched_pkg::*;

    logic                    valid;
    logic [FRAME_LEN_W-1:0]  len;
    logic [FRAME_TYPE_W-1:0] ftype;
    logic                    ack;

    modport master (output valid, output len, output ftype, input ack);
    modport slave  (input valid, input len, input ftype, output ack);

endinterface

// File: rtl/tx_frame_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer only moves when both requesters
// compete, so a lone requester never disturbs the fairness order.
module sched_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       update_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (valid0_i && valid1_i) begin
                grant_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant_o = {valid1_i, valid0_i};
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i && en_i && valid0_i && valid1_i) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/tx_frame_scheduler.sv
// Arbitrates frame requests from two requesters and drives the TX chain start
// strobes, one frame in flight, with tx_done timeout and inter-frame gap.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int IFS_CYCLES     = DEF_IFS_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_LEN        = DEF_MAX_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sched_en,
    tx_frame_scheduler_if.slave     req0,
    tx_frame_scheduler_if.slave     req1,
    input  logic                    tx_done,
    output logic                    new_frame,
    output logic                    frame_vld,
    output logic [FRAME_LEN_W-1:0]  frame_len,
    output logic [FRAME_TYPE_W-1:0] frame_type,
    output logic                    grant_id,
    output logic                    busy,
    output logic                    len_err,
    output logic                    timeout_err
);

    localparam int GAP_W      = $clog2((IFS_CYCLES > 1) ? IFS_CYCLES : 1) + 1;
    localparam int GAP_LAST_I = (IFS_CYCLES == 0) ? 0 : IFS_CYCLES - 1;
    localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(GAP_LAST_I);
    localparam logic [TIMEOUT_W-1:0]   TMO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FRAME_LEN_W-1:0] MAX_LEN_V = FRAME_LEN_W'(MAX_LEN);

    sched_state_e            state_q, state_d;
    logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    ack0_q, ack0_d, ack1_q, ack1_d;
    logic                    nf_q, nf_d, fv_q, fv_d;
    logic [FRAME_LEN_W-1:0]  len_q, len_d;
    logic [FRAME_TYPE_W-1:0] type_q, type_d;
    logic                    gid_q, gid_d;
    logic                    busy_q;
    logic                    lerr_q, lerr_d, terr_q, terr_d;

    logic                    arb_en, arb_decide, arb_ptr, win1;
    logic [1:0]              arb_grant;
    logic [FRAME_LEN_W-1:0]  win_len;
    logic [FRAME_TYPE_W-1:0] win_type;

    // Hold off arbitration while an ack is out: the requester only drops
    // valid after seeing it, so the same request must not be taken twice.
    assign arb_en = (state_q == IDLE) && sched_en && !ack0_q && !ack1_q;

    sched_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid0_i (req0.valid),
        .valid1_i (req1.valid),
        .update_i (arb_decide),
        .en_i     (arb_en),
        .grant_o  (arb_grant),
        .ptr_o    (arb_ptr)
    );

    assign arb_decide = |arb_grant;
    assign win1       = (req0.valid && req1.valid) ? arb_ptr : req1.valid;
    assign win_len    = win1 ? req1.len : req0.len;
    assign win_type   = win1 ? req1.ftype : req0.ftype;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        nf_d    = 1'b0;
        fv_d    = 1'b0;
        len_d   = len_q;
        type_d  = type_q;
        gid_d   = gid_q;
        lerr_d  = 1'b0;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_decide) begin
                    ack0_d = !win1;
                    ack1_d = win1;
                    if (len_ok(win_len, MAX_LEN_V)) begin
                        nf_d    = 1'b1;
                        len_d   = win_len;
                        type_d  = win_type;
                        gid_d   = win1;
                        state_d = LAUNCH;
                    end else begin
                        lerr_d = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                fv_d    = 1'b1;
                state_d = VLD;
            end
            VLD: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            gap_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            nf_q    <= 1'b0;
            fv_q    <= 1'b0;
            len_q   <= '0;
            type_q  <= '0;
            gid_q   <= 1'b0;
            busy_q  <= 1'b0;
            lerr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            nf_q    <= nf_d;
            fv_q    <= fv_d;
            len_q   <= len_d;
            type_q  <= type_d;
            gid_q   <= gid_d;
            busy_q  <= (state_d != IDLE);
            lerr_q  <= lerr_d;
            terr_q  <= terr_d;
        end
    end

    assign req0.ack    = ack0_q;
    assign req1.ack    = ack1_q;
    assign new_frame   = nf_q;
    assign frame_vld   = fv_q;
    assign frame_len   = len_q;
    assign frame_type  = type_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign len_err     = lerr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scenario bench for tx_frame_scheduler: each task drives one feature and
// checks grants against a queue of expected frames.
module tb_tx_frame_scheduler;
    import tx_sched_pkg::*;

    localparam int IFS = 16;
    localparam int TMO = 100;

    typedef struct {
        logic        id;
        logic [15:0] len;
        logic [3:0]  ftype;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        sched_en = 1'b0;
    logic        tx_done  = 1'b0;
    logic        new_frame, frame_vld, grant_id, busy, len_err, timeout_err;
    logic [15:0] frame_len;
    logic [3:0]  frame_type;

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t expQ[$];

    tx_frame_scheduler_if r0 ();
    tx_frame_scheduler_if r1 ();

    tx_frame_scheduler #(
        .IFS_CYCLES     (IFS),
        .TIMEOUT_CYCLES (TMO),
        .MAX_LEN        (4095)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sched_en    (sched_en),
        .req0        (r0),
        .req1        (r1),
        .tx_done     (tx_done),
        .new_frame   (new_frame),
        .frame_vld   (frame_vld),
        .frame_len   (frame_len),
        .frame_type  (frame_type),
        .grant_id    (grant_id),
        .busy        (busy),
        .len_err     (len_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        r0.valid = 1'b0; r0.len = '0; r0.ftype = '0;
        r1.valid = 1'b0; r1.len = '0; r1.ftype = '0;
        #2 rst = 1'b0;
        repeat (3) tick();
        testsRun++;
        if ({new_frame, frame_vld, grant_id, busy, len_err, timeout_err, r0.ack, r1.ack} !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got %b expected 00000000",
                     {new_frame, frame_vld, grant_id, busy, len_err, timeout_err, r0.ack, r1.ack});
        end
        testsRun++;
        if (frame_len !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_len: got %0d expected 0", frame_len);
        end
        testsRun++;
        if (frame_type !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_type: got %0d expected 0", frame_type);
        end
        rst = 1'b1;
        repeat (2) tick();
        testsRun++;
        if ({new_frame, busy, r0.ack, r1.ack} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL idle_after_reset: got %b expected 0000", {new_frame, busy, r0.ack, r1.ack});
        end
    endtask

    task automatic test_single;
        exp_t e;
        int   gapCycles;
        sched_en = 1'b1;
        r0.valid = 1'b1; r0.len = 16'd10; r0.ftype = 4'd0;
        expQ.push_back('{id: 1'b0, len: 16'd10, ftype: 4'd0});
        tick();
        testsRun++;
        if ({r0.ack, new_frame, busy} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL single_ack: got ack/nf/busy %b expected 111", {r0.ack, new_frame, busy});
        end
        e = expQ.pop_front();
        testsRun++;
        if (frame_len !== e.len) begin
            testsFailed++;
            $display("[TB] FAIL single_len: got %0d expected %0d", frame_len, e.len);
        end
        testsRun++;
        if (grant_id !== e.id) begin
            testsFailed++;
            $display("[TB] FAIL single_gid: got %0d expected %0d", grant_id, e.id);
        end
        r0.valid = 1'b0;
        tick();
        testsRun++;
        if ({frame_vld, new_frame, r0.ack} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL single_vld: got vld/nf/ack %b expected 100", {frame_vld, new_frame, r0.ack});
        end
        repeat (20) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        gapCycles = 0;
        while (busy === 1'b1 && gapCycles < 40) begin
            tick();
            gapCycles++;
        end
        testsRun++;
        if (gapCycles !== IFS) begin
            testsFailed++;
            $display("[TB] FAIL single_gap: got %0d busy cycles after gap entry expected %0d", gapCycles, IFS);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   waitCnt;
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_idle: got busy %b expected 0", busy);
        end
        for (int k = 0; k < 2; k++) begin
            expQ.push_back('{id: 1'b0, len: 16'd5, ftype: 4'd1});
            expQ.push_back('{id: 1'b1, len: 16'd7, ftype: 4'd2});
        end
        r0.len = 16'd5; r0.ftype = 4'd1; r0.valid = 1'b1;
        r1.len = 16'd7; r1.ftype = 4'd2; r1.valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            waitCnt = 0;
            do begin
                tick();
                waitCnt++;
            end while (new_frame !== 1'b1 && waitCnt < 60);
            testsRun++;
            if (new_frame !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL b2b_grant_wait: frame %0d got no new_frame within %0d cycles", f, waitCnt);
            end
            e = expQ.pop_front();
            testsRun++;
            if (grant_id !== e.id) begin
                testsFailed++;
                $display("[TB] FAIL b2b_order: frame %0d got id %0d expected %0d", f, grant_id, e.id);
            end
            testsRun++;
            if ({frame_len, frame_type} !== {e.len, e.ftype}) begin
                testsFailed++;
                $display("[TB] FAIL b2b_fields: frame %0d got len %0d type %0d expected len %0d type %0d",
                         f, frame_len, frame_type, e.len, e.ftype);
            end
            testsRun++;
            if ({r1.ack, r0.ack} !== (e.id ? 2'b10 : 2'b01)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_ack: frame %0d got acks %b expected %b", f, {r1.ack, r0.ack},
                         (e.id ? 2'b10 : 2'b01));
            end
            if (f == 3) begin
                r0.valid = 1'b0;
                r1.valid = 1'b0;
            end
            tick();
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        repeat (20) tick();
    endtask

    task automatic test_len_reject;
        logic [15:0] badLens [3];
        badLens = '{16'd0, 16'd5000, 16'd4096};
        for (int i = 0; i < 3; i++) begin
            r1.len = badLens[i]; r1.ftype = 4'd5; r1.valid = 1'b1;
            tick();
            testsRun++;
            if ({r1.ack, len_err, new_frame, busy, r0.ack} !== 5'b11000) begin
                testsFailed++;
                $display("[TB] FAIL reject_pulse: len %0d got ack/err/nf/busy/ack0 %b expected 11000",
                         badLens[i], {r1.ack, len_err, new_frame, busy, r0.ack});
            end
            r1.valid = 1'b0;
            tick();
            testsRun++;
            if ({frame_len, frame_type, grant_id, busy, frame_vld, len_err} !== {16'd7, 4'd2, 1'b1, 3'b000}) begin
                testsFailed++;
                $display("[TB] FAIL reject_hold: len %0d got len %0d type %0d id %0d busy/vld/err %b expected 7 2 1 000",
                         badLens[i], frame_len, frame_type, grant_id, {busy, frame_vld, len_err});
            end
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        int   cnt;
        int   gapCycles;
        r0.len = 16'd4095; r0.ftype = 4'd9; r0.valid = 1'b1;
        expQ.push_back('{id: 1'b0, len: 16'd4095, ftype: 4'd9});
        tick();
        testsRun++;
        if (new_frame !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL maxlen_accept: got new_frame %b expected 1", new_frame);
        end
        e = expQ.pop_front();
        testsRun++;
        if ({grant_id, frame_len, frame_type} !== {e.id, e.len, e.ftype}) begin
            testsFailed++;
            $display("[TB] FAIL maxlen_fields: got id %0d len %0d type %0d expected %0d %0d %0d",
                     grant_id, frame_len, frame_type, e.id, e.len, e.ftype);
        end
        r0.valid = 1'b0;
        tx_done  = 1'b1;
        tick();
        tick();
        tx_done = 1'b0;
        cnt = 0;
        while (timeout_err !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        testsRun++;
        if (cnt !== TMO) begin
            testsFailed++;
            $display("[TB] FAIL timeout_latency: got %0d cycles after wait entry expected %0d", cnt, TMO);
        end
        tick();
        testsRun++;
        if ({timeout_err, busy} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL timeout_pulse: got err/busy %b expected 01", {timeout_err, busy});
        end
        gapCycles = 1;
        while (busy === 1'b1 && gapCycles < 40) begin
            tick();
            gapCycles++;
        end
        testsRun++;
        if (gapCycles !== IFS) begin
            testsFailed++;
            $display("[TB] FAIL timeout_gap: got %0d gap cycles expected %0d", gapCycles, IFS);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        r0.len = 16'd33; r0.ftype = 4'd4; r0.valid = 1'b1;
        expQ.push_back('{id: 1'b0, len: 16'd33, ftype: 4'd4});
        tick();
        e = expQ.pop_front();
        testsRun++;
        if ({new_frame, frame_len} !== {1'b1, e.len}) begin
            testsFailed++;
            $display("[TB] FAIL midrst_first: got nf %b len %0d expected 1 %0d", new_frame, frame_len, e.len);
        end
        repeat (4) tick();
        #3 rst = 1'b0;
        #1;
        testsRun++;
        if ({new_frame, frame_vld, grant_id, busy, len_err, timeout_err, r0.ack, r1.ack, frame_len, frame_type} !== 28'd0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_clear: got flags %b len %0d type %0d expected all 0",
                     {new_frame, frame_vld, grant_id, busy, len_err, timeout_err, r0.ack, r1.ack},
                     frame_len, frame_type);
        end
        expQ.push_back('{id: 1'b0, len: 16'd33, ftype: 4'd4});
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        e = expQ.pop_front();
        testsRun++;
        if ({new_frame, r0.ack, grant_id, frame_len, frame_type} !== {2'b11, e.id, e.len, e.ftype}) begin
            testsFailed++;
            $display("[TB] FAIL midrst_regrant: got nf/ack %b id %0d len %0d type %0d expected 11 %0d %0d %0d",
                     {new_frame, r0.ack}, grant_id, frame_len, frame_type, e.id, e.len, e.ftype);
        end
        r0.valid = 1'b0;
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_sched_en;
        exp_t e;
        int   ackSeen;
        int   gapCycles;
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL en_idle: got busy %b expected 0", busy);
        end
        sched_en = 1'b0;
        r0.len = 16'd12; r0.ftype = 4'd6; r0.valid = 1'b1;
        ackSeen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (r0.ack === 1'b1 || new_frame === 1'b1) ackSeen++;
        end
        testsRun++;
        if (ackSeen !== 0) begin
            testsFailed++;
            $display("[TB] FAIL en_blocked: got %0d ack cycles expected 0", ackSeen);
        end
        sched_en = 1'b1;
        expQ.push_back('{id: 1'b0, len: 16'd12, ftype: 4'd6});
        tick();
        e = expQ.pop_front();
        testsRun++;
        if ({r0.ack, new_frame, frame_len, frame_type} !== {2'b11, e.len, e.ftype}) begin
            testsFailed++;
            $display("[TB] FAIL en_grant: got ack/nf %b len %0d type %0d expected 11 %0d %0d",
                     {r0.ack, new_frame}, frame_len, frame_type, e.len, e.ftype);
        end
        r0.valid = 1'b0;
        sched_en = 1'b0;
        tick();
        testsRun++;
        if (frame_vld !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL en_inflight_vld: got %b expected 1", frame_vld);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        gapCycles = 0;
        while (busy === 1'b1 && gapCycles < 40) begin
            tick();
            gapCycles++;
        end
        testsRun++;
        if (gapCycles !== IFS) begin
            testsFailed++;
            $display("[TB] FAIL en_inflight_gap: got %0d gap cycles expected %0d", gapCycles, IFS);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_len_reject();
        test_timeout();
        test_reset_mid();
        test_sched_en();
        testsRun++;
        if (expQ.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
